// File: rtl/c3lib_ckmux_pkg.sv
// Shared types and limits for the software-controlled N:1 clock-mux sequencer.
package c3lib_ckmux_pkg;

  localparam int CKMUX_MAX_NUM_CK = 16;

  typedef enum logic [1:0] {
    RST_SETTLE = 2'd0,
    IDLE       = 2'd1,
    DRAIN      = 2'd2,
    SETTLE     = 2'd3
  } ckmux_sw_state_e;

  function automatic int ckmux_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/c3lib_ckmux_dly_cnt.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module c3lib_ckmux_dly_cnt
  import c3lib_ckmux_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign done = (cnt_reg == '0);

endmodule

// File: rtl/c3lib_ckmuxn_sw_ctrl.sv
// Glitch-safe select sequencer for an N-input clock mux: gate off, move the
// select, wait for it to settle, gate back on. Scan override bypasses it all.
module c3lib_ckmuxn_sw_ctrl
  import c3lib_ckmux_pkg::*;
#(
  parameter int NUM_CK     = 4,
  parameter int SEL_W      = $clog2(NUM_CK),
  parameter int GATE_DLY   = 2,
  parameter int SETTLE_DLY = 3,
  parameter int CNT_W      = $clog2(ckmux_max(GATE_DLY, SETTLE_DLY) + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             sel_req_vld,
  output logic             sel_req_rdy,
  output logic             sel_ack,
  output logic             sel_err,
  output logic             busy,
  output logic [SEL_W-1:0] mux_sel,
  output logic             ck_gate_en,
  input  logic             tst_override,
  input  logic [SEL_W-1:0] tst_sel
);

  if (NUM_CK < 2 || NUM_CK > CKMUX_MAX_NUM_CK) begin : g_bad_num_ck
    $error("c3lib_ckmuxn_sw_ctrl: NUM_CK=%0d out of range 2..%0d", NUM_CK, CKMUX_MAX_NUM_CK);
  end
  if (SEL_W != $clog2(NUM_CK)) begin : g_bad_sel_w
    $error("c3lib_ckmuxn_sw_ctrl: SEL_W=%0d must equal clog2(NUM_CK)", SEL_W);
  end
  if (GATE_DLY < 1 || SETTLE_DLY < 1) begin : g_bad_dly
    $error("c3lib_ckmuxn_sw_ctrl: GATE_DLY and SETTLE_DLY must be >= 1");
  end
  if (CNT_W < $clog2(ckmux_max(GATE_DLY, SETTLE_DLY) + 1)) begin : g_bad_cnt_w
    $error("c3lib_ckmuxn_sw_ctrl: CNT_W=%0d too narrow for the delays", CNT_W);
  end

  // The counter is loaded with DLY-1 so that a state lasts exactly DLY cycles.
  localparam logic [CNT_W-1:0] GATE_LD   = CNT_W'(GATE_DLY - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_DLY - 1);
  localparam logic [SEL_W:0]   NUM_CK_L  = (SEL_W + 1)'(NUM_CK);

  ckmux_sw_state_e  state_reg, state_next;
  logic [SEL_W-1:0] sel_reg, sel_next;
  logic [SEL_W-1:0] target_reg, target_next;
  logic             gate_reg, gate_next;
  logic             ack_reg, ack_next;
  logic             err_reg, err_next;
  logic             armed_reg, armed_next;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_done;
  logic             req_oob;

  assign req_oob = ({1'b0, sel_req} >= NUM_CK_L);

  c3lib_ckmux_dly_cnt #(
    .CNT_W (CNT_W)
  ) u_dly_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .done     (cnt_done)
  );

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    target_next  = target_reg;
    gate_next    = gate_reg;
    ack_next     = 1'b0;
    err_next     = 1'b0;
    armed_next   = armed_reg;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (tst_override) begin
      // Abort any sequence; leave the gate open so the registered path is live on exit.
      if (state_reg != IDLE) begin
        state_next = IDLE;
        gate_next  = 1'b1;
      end
    end else begin
      case (state_reg)
        RST_SETTLE: begin
          if (!armed_reg) begin
            cnt_load     = 1'b1;
            cnt_load_val = SETTLE_LD;
            armed_next   = 1'b1;
          end else if (cnt_done) begin
            state_next = IDLE;
            gate_next  = 1'b1;
          end
        end
        IDLE: begin
          if (sel_req_vld) begin
            if (req_oob) begin
              err_next = 1'b1;
            end else if (sel_req == sel_reg) begin
              ack_next = 1'b1;
            end else begin
              target_next  = sel_req;
              gate_next    = 1'b0;
              state_next   = DRAIN;
              cnt_load     = 1'b1;
              cnt_load_val = GATE_LD;
            end
          end
        end
        DRAIN: begin
          if (cnt_done) begin
            sel_next     = target_reg;
            state_next   = SETTLE;
            cnt_load     = 1'b1;
            cnt_load_val = SETTLE_LD;
          end
        end
        SETTLE: begin
          if (cnt_done) begin
            gate_next  = 1'b1;
            ack_next   = 1'b1;
            state_next = IDLE;
          end
        end
        default: state_next = RST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= RST_SETTLE;
      sel_reg    <= '0;
      target_reg <= '0;
      gate_reg   <= 1'b0;
      ack_reg    <= 1'b0;
      err_reg    <= 1'b0;
      armed_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      sel_reg    <= sel_next;
      target_reg <= target_next;
      gate_reg   <= gate_next;
      ack_reg    <= ack_next;
      err_reg    <= err_next;
      armed_reg  <= armed_next;
    end
  end

  assign sel_req_rdy = (state_reg == IDLE) & ~tst_override;
  assign busy        = (state_reg != IDLE);
  assign sel_ack     = ack_reg;
  assign sel_err     = err_reg;
  assign mux_sel     = tst_override ? tst_sel : sel_reg;
  assign ck_gate_en  = tst_override | gate_reg;

endmodule

// File: tb/tb_c3lib_ckmuxn_sw_ctrl.sv
// Self-checking bench: four parameterisations driven in turn against a
// cycle-schedule model of the request/gate/select timeline.
module tb_c3lib_ckmuxn_sw_ctrl;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a [4];
  logic [3:0] req_a   [4];
  logic       vld_a   [4];
  logic       ovr_a   [4];
  logic [3:0] tsel_a  [4];
  logic       rdy_v   [4];
  logic       ack_v   [4];
  logic       err_v   [4];
  logic       busy_v  [4];
  logic       gate_v  [4];
  logic [3:0] mux_v   [4];
  logic [1:0] mux0, mux1;
  logic [0:0] mux2;
  logic [3:0] mux3;

  assign mux_v[0] = {2'b00, mux0};
  assign mux_v[1] = {2'b00, mux1};
  assign mux_v[2] = {3'b000, mux2};
  assign mux_v[3] = mux3;

  c3lib_ckmuxn_sw_ctrl #(.NUM_CK(4), .GATE_DLY(2), .SETTLE_DLY(3)) u_dut0 (
    .clk(clk), .rst_n(rst_n_a[0]), .sel_req(req_a[0][1:0]), .sel_req_vld(vld_a[0]),
    .sel_req_rdy(rdy_v[0]), .sel_ack(ack_v[0]), .sel_err(err_v[0]), .busy(busy_v[0]),
    .mux_sel(mux0), .ck_gate_en(gate_v[0]), .tst_override(ovr_a[0]), .tst_sel(tsel_a[0][1:0]));
  c3lib_ckmuxn_sw_ctrl #(.NUM_CK(3), .GATE_DLY(2), .SETTLE_DLY(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n_a[1]), .sel_req(req_a[1][1:0]), .sel_req_vld(vld_a[1]),
    .sel_req_rdy(rdy_v[1]), .sel_ack(ack_v[1]), .sel_err(err_v[1]), .busy(busy_v[1]),
    .mux_sel(mux1), .ck_gate_en(gate_v[1]), .tst_override(ovr_a[1]), .tst_sel(tsel_a[1][1:0]));
  c3lib_ckmuxn_sw_ctrl #(.NUM_CK(2), .GATE_DLY(1), .SETTLE_DLY(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n_a[2]), .sel_req(req_a[2][0:0]), .sel_req_vld(vld_a[2]),
    .sel_req_rdy(rdy_v[2]), .sel_ack(ack_v[2]), .sel_err(err_v[2]), .busy(busy_v[2]),
    .mux_sel(mux2), .ck_gate_en(gate_v[2]), .tst_override(ovr_a[2]), .tst_sel(tsel_a[2][0:0]));
  c3lib_ckmuxn_sw_ctrl #(.NUM_CK(16), .GATE_DLY(1), .SETTLE_DLY(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n_a[3]), .sel_req(req_a[3]), .sel_req_vld(vld_a[3]),
    .sel_req_rdy(rdy_v[3]), .sel_ack(ack_v[3]), .sel_err(err_v[3]), .busy(busy_v[3]),
    .mux_sel(mux3), .ck_gate_en(gate_v[3]), .tst_override(ovr_a[3]), .tst_sel(tsel_a[3]));

  function automatic int cfg_n(input int k);
    case (k) 0: return 4; 1: return 3; 2: return 2; default: return 16; endcase
  endfunction
  function automatic int cfg_g(input int k);
    return (k < 2) ? 2 : 1;
  endfunction
  function automatic int cfg_s(input int k);
    return (k < 2) ? 3 : 1;
  endfunction
  function automatic int cfg_w(input int k);
    case (k) 0: return 2; 1: return 2; 2: return 1; default: return 4; endcase
  endfunction

  int tests = 0;
  int fails = 0;
  int cur_k, c_n, c_g, c_s, c_w;

  // Model: absolute cycle index since reset release and the cycles at which
  // the pending request moves the select and completes.
  int m_now, m_t_idle, m_t_move, m_sel, m_target;
  bit m_inflight, m_gate, m_ack, m_err;

  logic [3:0] prev_mux;
  logic       prev_gate;
  bit         prev_ovr, prev_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cfg=%0d cyc=%0d: got %0d required %0d", name, cur_k, m_now, act, exp);
    end
  endtask

  task automatic model_reset();
    m_now = 0; m_t_idle = c_s + 1; m_t_move = 0; m_sel = 0; m_target = 0;
    m_inflight = 0; m_gate = 0; m_ack = 0; m_err = 0;
    prev_valid = 0;
  endtask

  task automatic model_step(input bit vld, input int req, input bit ovr);
    int nxt;
    nxt = m_now + 1;
    m_ack = 0;
    m_err = 0;
    if (ovr) begin
      if (m_now < m_t_idle) begin
        m_inflight = 0;
        m_t_idle = nxt;
        m_gate = 1;
      end
    end else if (m_now < m_t_idle) begin
      if (m_inflight && nxt == m_t_move) m_sel = m_target;
      if (nxt == m_t_idle) begin
        m_gate = 1;
        if (m_inflight) begin
          m_ack = 1;
          $display("[TB] cfg=%0d cyc=%0d switch to %0d complete", cur_k, nxt, m_target);
        end
        m_inflight = 0;
      end
    end else if (vld) begin
      if (req >= c_n) begin
        m_err = 1;
        $display("[TB] cfg=%0d cyc=%0d request %0d rejected", cur_k, nxt, req);
      end else if (req == m_sel) begin
        m_ack = 1;
        $display("[TB] cfg=%0d cyc=%0d request %0d already selected", cur_k, nxt, req);
      end else begin
        m_inflight = 1;
        m_target = req;
        m_gate = 0;
        m_t_move = nxt + c_g;
        m_t_idle = nxt + c_g + c_s;
      end
    end
    m_now = nxt;
  endtask

  task automatic compare(input int k, input bit ovr, input int tsel);
    logic [3:0] em;
    bit eb;
    em = ovr ? 4'(tsel) : 4'(m_sel);
    eb = (m_now < m_t_idle);
    chk("mux_sel", mux_v[k], em);
    chk("ck_gate_en", gate_v[k], ovr | m_gate);
    chk("busy", busy_v[k], eb);
    chk("sel_req_rdy", rdy_v[k], !eb && !ovr);
    chk("sel_ack", ack_v[k], m_ack);
    chk("sel_err", err_v[k], m_err);
    if (prev_valid && !ovr && !prev_ovr && mux_v[k] !== prev_mux)
      chk("sel_moved_while_gated", prev_gate | gate_v[k], 0);
    prev_mux = mux_v[k];
    prev_gate = gate_v[k];
    prev_ovr = ovr;
    prev_valid = 1;
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic step(input int k, input bit vld, input int req, input bit ovr, input int tsel);
    vld_a[k] = vld;
    req_a[k] = 4'(req);
    ovr_a[k] = ovr;
    tsel_a[k] = 4'(tsel);
    #1;
    compare(k, ovr, tsel);
    model_step(vld, req, ovr);
    @(negedge clk);
  endtask

  task automatic idle(input int k, input int n);
    for (int i = 0; i < n; i++) step(k, 0, 0, 0, 0);
  endtask

  task automatic do_reset(input int k);
    vld_a[k] = 0; req_a[k] = 0; ovr_a[k] = 0; tsel_a[k] = 0;
    rst_n_a[k] = 0;
    #1;
    chk("rst_mux_sel", mux_v[k], 0);
    chk("rst_gate", gate_v[k], 0);
    chk("rst_rdy", rdy_v[k], 0);
    chk("rst_ack", ack_v[k], 0);
    chk("rst_err", err_v[k], 0);
    chk("rst_busy", busy_v[k], 1);
    @(negedge clk);
    @(negedge clk);
    rst_n_a[k] = 1;
    model_reset();
  endtask

  task automatic random_phase(input int k, input int n);
    int hold;
    bit ovr;
    hold = 0;
    for (int i = 0; i < n; i++) begin
      if (hold > 0) hold--;
      else if ($urandom_range(0, 39) == 0) hold = 1 + $urandom_range(0, 3);
      ovr = (hold > 0);
      step(k, 1'($urandom_range(0, 1)), $urandom_range(0, (1 << c_w) - 1), ovr,
           $urandom_range(0, (1 << c_w) - 1));
    end
    idle(k, c_g + c_s + 2);
  endtask

  task automatic select_cfg(input int k);
    cur_k = k; c_n = cfg_n(k); c_g = cfg_g(k); c_s = cfg_s(k); c_w = cfg_w(k);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) begin
      rst_n_a[k] = 0; req_a[k] = 0; vld_a[k] = 0; ovr_a[k] = 0; tsel_a[k] = 0;
    end
    @(negedge clk);

    // Defaults: reset release, full switch, same-select, override in SETTLE.
    select_cfg(0);
    do_reset(0);
    chk("rel_gate_c0", gate_v[0], 0);
    idle(0, 3);
    chk("rel_gate_c3", gate_v[0], 0);
    idle(0, 1);
    chk("rel_gate_c4", gate_v[0], 1);
    chk("rel_mux", mux_v[0], 0);
    chk("rel_ack", ack_v[0], 0);
    step(0, 1, 2, 0, 0);
    chk("sw_gate_t1", gate_v[0], 0);
    chk("sw_rdy_t1", rdy_v[0], 0);
    idle(0, 1);
    chk("sw_mux_t2", mux_v[0], 0);
    idle(0, 1);
    chk("sw_mux_t3", mux_v[0], 2);
    idle(0, 2);
    chk("sw_ack_t5", ack_v[0], 0);
    idle(0, 1);
    chk("sw_ack_t6", ack_v[0], 1);
    chk("sw_gate_t6", gate_v[0], 1);
    chk("sw_rdy_t6", rdy_v[0], 1);
    step(0, 1, 2, 0, 0);
    chk("same_ack", ack_v[0], 1);
    chk("same_gate", gate_v[0], 1);
    step(0, 1, 1, 0, 0);
    idle(0, 2);
    step(0, 0, 0, 1, 3);
    chk("ovr_mux", mux_v[0], 3);
    chk("ovr_gate", gate_v[0], 1);
    chk("ovr_busy", busy_v[0], 0);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0);
    chk("post_ovr_rdy", rdy_v[0], 1);
    chk("post_ovr_mux", mux_v[0], 1);
    random_phase(0, 300);

    // NUM_CK=3: out-of-range reject, same-select ack, reset during DRAIN.
    select_cfg(1);
    do_reset(1);
    idle(1, c_s + 1);
    step(1, 1, 3, 0, 0);
    chk("err_pulse", err_v[1], 1);
    chk("err_mux", mux_v[1], 0);
    chk("err_gate", gate_v[1], 1);
    step(1, 1, 0, 0, 0);
    chk("same0_ack", ack_v[1], 1);
    chk("same0_gate", gate_v[1], 1);
    step(1, 1, 2, 0, 0);
    idle(1, 6);
    chk("c1_mux2", mux_v[1], 2);
    step(1, 1, 1, 0, 0);
    do_reset(1);
    idle(1, c_s + 1);
    random_phase(1, 300);

    // Minimum delays at both ends of the NUM_CK range: latency 1+G+S = 3.
    for (int k = 2; k < 4; k++) begin
      select_cfg(k);
      do_reset(k);
      idle(k, c_s + 1);
      step(k, 1, c_n - 1, 0, 0);
      chk("min_gate_t1", gate_v[k], 0);
      idle(k, 1);
      chk("min_mux_t2", mux_v[k], c_n - 1);
      chk("min_ack_t2", ack_v[k], 0);
      idle(k, 1);
      chk("min_ack_t3", ack_v[k], 1);
      chk("min_gate_t3", gate_v[k], 1);
      random_phase(k, 300);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
